bufm_id_mgr: RTL and testbench

- Buffer-ID manager for the packet buffer (data_cache) written by the input buffer module.
- Holds a free list of buffer IDs and hands the head ID to the ingress path for the next packet.
- Reclaims IDs returned by the egress scheduler once a packet is transmitted.
- Exports the free-ID count; the ingress path uses it as its ID count / back-pressure input.

---
 rtl/bufm_id_mgr_pkg.sv | 11 +
 rtl/bufm_id_mgr_if.sv | 27 ++
 rtl/bufm_free_fifo.sv | 37 +++
 rtl/bufm_id_mgr.sv | 93 +++++++++
 tb/tb_bufm_id_mgr.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bufm_id_mgr_pkg.sv
// tsn_bufm_pkg: shared defaults and FSM encoding for the buffer-ID manager.
package tsn_bufm_pkg;
  localparam int BUFM_ID_W = 8;
  localparam int BUFM_NUM_BUF = 16;
  localparam int BUFM_CNT_W = 5;
  localparam int BUFM_LOW_WM = 2;
  typedef enum logic {
    INIT_S  = 1'b0,
    READY_S = 1'b1
  } state_t;
endpackage

// File: rtl/bufm_id_mgr_if.sv
// bufm_id_mgr_if: allocate/release bus between ingress/egress (master) and ID manager (slave).
interface bufm_id_mgr_if #(
  parameter int ID_W = 8,
  parameter int CNT_W = 5
) ();
  logic            in_alloc_req;
  logic [ID_W-1:0] in_rel_id;
  logic            in_rel_wr;
  logic [ID_W-1:0] out_id;
  logic            out_id_vld;
  logic [CNT_W-1:0] out_free_cnt;
  logic            out_almost_empty;
  logic            out_alloc_fail;
  logic            out_rel_err;
  logic [15:0]     out_drop_cnt;
  logic            out_init_done;
  modport master (
    output in_alloc_req, in_rel_id, in_rel_wr,
    input  out_id, out_id_vld, out_free_cnt, out_almost_empty,
    input  out_alloc_fail, out_rel_err, out_drop_cnt, out_init_done
  );
  modport slave (
    input  in_alloc_req, in_rel_id, in_rel_wr,
    output out_id, out_id_vld, out_free_cnt, out_almost_empty,
    output out_alloc_fail, out_rel_err, out_drop_cnt, out_init_done
  );
endinterface

// File: rtl/bufm_free_fifo.sv
// bufm_free_fifo: register-array circular FIFO holding free buffer IDs.
module bufm_free_fifo #(
  parameter int DEPTH = 16,
  parameter int ID_W = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [ID_W-1:0]  i_push_data,
  input  logic             i_pop,
  output logic [ID_W-1:0]  o_head,
  output logic [CNT_W-1:0] o_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [ID_W-1:0]  r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '{default: '0};
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end
  assign o_head = r_mem[r_rd_ptr];
  assign o_cnt = r_cnt;
endmodule

// File: rtl/bufm_id_mgr.sv
// bufm_id_mgr: init sequencer, allocation bitmap, release legality and error/drop counters
// wrapped around the free-ID FIFO.
module bufm_id_mgr
  import tsn_bufm_pkg::*;
#(
  parameter int ID_W = BUFM_ID_W,
  parameter int NUM_BUF = BUFM_NUM_BUF,
  parameter int CNT_W = BUFM_CNT_W,
  parameter int LOW_WM = BUFM_LOW_WM
) (
  input logic clk,
  input logic rst,
  bufm_id_mgr_if.slave bus
);
  localparam int AW = $clog2(NUM_BUF);
  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_init_k;
  logic [NUM_BUF-1:0] r_bitmap;
  logic             r_alloc_fail;
  logic             r_rel_err;
  logic             r_almost_empty;
  logic [15:0]      r_drop_cnt;
  logic             w_vld;
  logic             w_alloc;
  logic             w_fail;
  logic             w_rel_ok;
  logic             w_rel_err;
  logic             w_push;
  logic [ID_W-1:0]  w_head;
  logic [ID_W-1:0]  w_push_data;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [AW-1:0]    w_rel_idx;
  logic [AW-1:0]    w_head_idx;
  assign w_rel_idx = bus.in_rel_id[AW-1:0];
  assign w_head_idx = w_head[AW-1:0];
  // A release is only legal for an in-range ID that is currently handed out.
  always_comb begin
    w_vld = r_state == READY_S && w_cnt != '0;
    w_alloc = bus.in_alloc_req && w_vld;
    w_fail = bus.in_alloc_req && !w_vld;
    w_rel_ok = bus.in_rel_wr && r_state == READY_S && bus.in_rel_id < ID_W'(NUM_BUF) && r_bitmap[w_rel_idx];
    w_rel_err = bus.in_rel_wr && !w_rel_ok;
    w_push = r_state == INIT_S || w_rel_ok;
    w_push_data = r_state == INIT_S ? ID_W'(r_init_k) : bus.in_rel_id;
    w_cnt_nxt = w_cnt + CNT_W'(w_push) - CNT_W'(w_alloc);
    w_state_nxt = (r_state == INIT_S && r_init_k == AW'(NUM_BUF - 1)) ? READY_S : r_state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= INIT_S;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_init_k <= '0;
      r_bitmap <= '0;
      r_alloc_fail <= 1'b0;
      r_rel_err <= 1'b0;
      r_almost_empty <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (r_state == INIT_S) r_init_k <= r_init_k + AW'(1);
      if (w_alloc) r_bitmap[w_head_idx] <= 1'b1;
      if (w_rel_ok) r_bitmap[w_rel_idx] <= 1'b0;
      if (w_fail && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      r_alloc_fail <= w_fail;
      r_rel_err <= w_rel_err;
      r_almost_empty <= w_cnt_nxt <= CNT_W'(LOW_WM);
    end
  end
  bufm_free_fifo #(
    .DEPTH(NUM_BUF),
    .ID_W(ID_W),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(w_push),
    .i_push_data(w_push_data),
    .i_pop(w_alloc),
    .o_head(w_head),
    .o_cnt(w_cnt)
  );
  assign bus.out_id = w_head;
  assign bus.out_id_vld = w_vld;
  assign bus.out_free_cnt = w_cnt;
  assign bus.out_almost_empty = r_almost_empty;
  assign bus.out_alloc_fail = r_alloc_fail;
  assign bus.out_rel_err = r_rel_err;
  assign bus.out_drop_cnt = r_drop_cnt;
  assign bus.out_init_done = r_state == READY_S;
endmodule

// File: tb/tb_bufm_id_mgr.sv
// tb_bufm_id_mgr: directed and randomized checks of bufm_id_mgr against a queue-based model.
module tb_bufm_id_mgr;
  localparam int NUM = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int q[$];
  bit m_alloc[NUM];
  bit m_ready, m_fail, m_err, m_ae;
  int m_k, m_drop;
  bufm_id_mgr_if #(.ID_W(8), .CNT_W(5)) bus ();
  bufm_id_mgr dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic model_reset();
    q.delete();
    foreach (m_alloc[i]) m_alloc[i] = 1'b0;
    m_ready = 0; m_k = 0; m_fail = 0; m_err = 0; m_ae = 0; m_drop = 0;
  endtask
  task automatic cycle(input bit req, input bit wr, input logic [7:0] id);
    bit vld, aok, legal;
    bus.in_alloc_req = req;
    bus.in_rel_wr = wr;
    bus.in_rel_id = id;
    vld = m_ready && q.size() > 0;
    aok = req && vld;
    legal = wr && m_ready && id < 8'(NUM) && m_alloc[id[3:0]];
    @(posedge clk);
    #1;
    bus.in_alloc_req = 1'b0;
    bus.in_rel_wr = 1'b0;
    if (!m_ready) begin
      q.push_back(m_k);
      m_k++;
      if (m_k == NUM) m_ready = 1;
    end else begin
      if (aok) begin
        m_alloc[q[0]] = 1;
        void'(q.pop_front());
      end
      if (legal) begin
        q.push_back(int'(id));
        m_alloc[id[3:0]] = 0;
      end
    end
    m_fail = req && !vld;
    m_err = wr && !legal;
    if (m_fail && m_drop < 65535) m_drop++;
    m_ae = q.size() <= 2;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({bus.out_id, bus.out_id_vld, bus.out_free_cnt, bus.out_almost_empty, bus.out_alloc_fail,
         bus.out_rel_err, bus.out_drop_cnt, bus.out_init_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: id=%0h vld=%b cnt=%0d ae=%b af=%b re=%b drop=%0d done=%b, required all 0",
               bus.out_id, bus.out_id_vld, bus.out_free_cnt, bus.out_almost_empty, bus.out_alloc_fail,
               bus.out_rel_err, bus.out_drop_cnt, bus.out_init_done);
    end
    rst = 1'b0;
    repeat (NUM - 1) cycle(0, 0, 0);
    n_chk++;
    if (bus.out_init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL init_early: done=%b required 0 after %0d cycles", bus.out_init_done, NUM - 1);
    end
    n_chk++;
    if (bus.out_free_cnt !== 5'(NUM - 1)) begin
      n_fail++;
      $display("FAIL init_cnt_ramp: got %0d required %0d", bus.out_free_cnt, NUM - 1);
    end
    cycle(0, 0, 0);
    n_chk++;
    if (bus.out_init_done !== 1'b1 || bus.out_free_cnt !== 5'(NUM) || bus.out_id !== 8'd0 ||
        bus.out_id_vld !== 1'b1 || bus.out_almost_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL init_done: done=%b cnt=%0d id=%0d vld=%b ae=%b required 1 16 0 1 0",
               bus.out_init_done, bus.out_free_cnt, bus.out_id, bus.out_id_vld, bus.out_almost_empty);
    end
  endtask
  task automatic test_drain();
    for (int i = 0; i < NUM; i++) begin
      n_chk++;
      if (bus.out_id !== 8'(i) || bus.out_id_vld !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_id[%0d]: id=%0d vld=%b required %0d 1", i, bus.out_id, bus.out_id_vld, i);
      end
      cycle(1, 0, 0);
    end
    n_chk++;
    if (bus.out_free_cnt !== 5'd0 || bus.out_id_vld !== 1'b0 || bus.out_almost_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: cnt=%0d vld=%b ae=%b required 0 0 1",
               bus.out_free_cnt, bus.out_id_vld, bus.out_almost_empty);
    end
    cycle(1, 0, 0);
    n_chk++;
    if (bus.out_alloc_fail !== 1'b1 || bus.out_drop_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL alloc_fail_empty: fail=%b drop=%0d required 1 1", bus.out_alloc_fail, bus.out_drop_cnt);
    end
    cycle(0, 0, 0);
    n_chk++;
    if (bus.out_alloc_fail !== 1'b0 || bus.out_drop_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL alloc_fail_pulse: fail=%b drop=%0d required 0 1", bus.out_alloc_fail, bus.out_drop_cnt);
    end
  endtask
  task automatic test_release_order();
    cycle(0, 1, 8'd7);
    cycle(0, 1, 8'd3);
    n_chk++;
    if (bus.out_free_cnt !== 5'd2 || bus.out_rel_err !== 1'b0 || bus.out_almost_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL release_cnt: cnt=%0d err=%b ae=%b required 2 0 1",
               bus.out_free_cnt, bus.out_rel_err, bus.out_almost_empty);
    end
    n_chk++;
    if (bus.out_id !== 8'd7) begin
      n_fail++;
      $display("FAIL fifo_order_1: got %0d required 7", bus.out_id);
    end
    cycle(1, 0, 0);
    n_chk++;
    if (bus.out_id !== 8'd3) begin
      n_fail++;
      $display("FAIL fifo_order_2: got %0d required 3", bus.out_id);
    end
    cycle(1, 0, 0);
    n_chk++;
    if (bus.out_free_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL reorder_empty: got %0d required 0", bus.out_free_cnt);
    end
  endtask
  task automatic test_errors();
    cycle(0, 1, 8'd7);
    n_chk++;
    if (bus.out_rel_err !== 1'b0 || bus.out_free_cnt !== 5'd1) begin
      n_fail++;
      $display("FAIL first_release: err=%b cnt=%0d required 0 1", bus.out_rel_err, bus.out_free_cnt);
    end
    cycle(0, 1, 8'd7);
    n_chk++;
    if (bus.out_rel_err !== 1'b1 || bus.out_free_cnt !== 5'd1) begin
      n_fail++;
      $display("FAIL double_free: err=%b cnt=%0d required 1 1", bus.out_rel_err, bus.out_free_cnt);
    end
    cycle(0, 1, 8'd20);
    n_chk++;
    if (bus.out_rel_err !== 1'b1 || bus.out_free_cnt !== 5'd1) begin
      n_fail++;
      $display("FAIL out_of_range: err=%b cnt=%0d required 1 1", bus.out_rel_err, bus.out_free_cnt);
    end
    cycle(0, 1, 8'h83);
    n_chk++;
    if (bus.out_rel_err !== 1'b1 || bus.out_free_cnt !== 5'd1) begin
      n_fail++;
      $display("FAIL upper_bits: err=%b cnt=%0d required 1 1", bus.out_rel_err, bus.out_free_cnt);
    end
    cycle(0, 0, 0);
    n_chk++;
    if (bus.out_rel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rel_err_pulse: got %b required 0", bus.out_rel_err);
    end
  endtask
  task automatic test_simultaneous();
    int guard;
    cycle(0, 1, 8'd0);
    cycle(0, 1, 8'd1);
    cycle(0, 1, 8'd2);
    cycle(0, 1, 8'd4);
    n_chk++;
    if (bus.out_free_cnt !== 5'd5) begin
      n_fail++;
      $display("FAIL setup_cnt5: got %0d required 5", bus.out_free_cnt);
    end
    cycle(1, 1, 8'd5);
    n_chk++;
    if (bus.out_free_cnt !== 5'd5 || bus.out_rel_err !== 1'b0 || bus.out_alloc_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL alloc_rel_same_cycle: cnt=%0d err=%b fail=%b required 5 0 0",
               bus.out_free_cnt, bus.out_rel_err, bus.out_alloc_fail);
    end
    cycle(1, 1, bus.out_id);
    n_chk++;
    if (bus.out_rel_err !== 1'b1 || bus.out_free_cnt !== 5'd4) begin
      n_fail++;
      $display("FAIL same_id_release: err=%b cnt=%0d required 1 4", bus.out_rel_err, bus.out_free_cnt);
    end
    guard = 0;
    while (bus.out_id_vld === 1'b1 && guard < 32) begin
      cycle(1, 0, 0);
      guard++;
    end
    n_chk++;
    if (bus.out_free_cnt !== 5'd0 || guard != 4) begin
      n_fail++;
      $display("FAIL drain_to_empty: cnt=%0d allocs=%0d required 0 4", bus.out_free_cnt, guard);
    end
    cycle(1, 1, 8'd6);
    n_chk++;
    if (bus.out_alloc_fail !== 1'b1 || bus.out_rel_err !== 1'b0 || bus.out_free_cnt !== 5'd1 ||
        bus.out_id_vld !== 1'b1 || bus.out_id !== 8'd6) begin
      n_fail++;
      $display("FAIL empty_alloc_rel: fail=%b err=%b cnt=%0d vld=%b id=%0d required 1 0 1 1 6",
               bus.out_alloc_fail, bus.out_rel_err, bus.out_free_cnt, bus.out_id_vld, bus.out_id);
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      int al[$];
      bit req, wr;
      logic [7:0] id;
      int r;
      if (q.size() > 0) begin
        n_chk++;
        if (bus.out_id !== 8'(q[0]) || bus.out_id_vld !== 1'b1) begin
          n_fail++;
          $display("FAIL rnd_head[%0d]: id=%0d vld=%b required %0d 1", n, bus.out_id, bus.out_id_vld, q[0]);
        end
      end else begin
        n_chk++;
        if (bus.out_id_vld !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_vld[%0d]: got %b required 0", n, bus.out_id_vld);
        end
      end
      for (int i = 0; i < NUM; i++) if (m_alloc[i]) al.push_back(i);
      req = $urandom_range(0, 1) == 1;
      wr = $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 9);
      if (r < 7 && al.size() > 0) id = 8'(al[$urandom_range(0, al.size() - 1)]);
      else if (r == 7 && q.size() > 0) id = 8'(q[0]);
      else if (r == 8) id = 8'($urandom_range(0, NUM - 1));
      else id = 8'($urandom_range(0, 255));
      cycle(req, wr, id);
      n_chk++;
      if (bus.out_free_cnt !== 5'(q.size()) || bus.out_almost_empty !== m_ae || bus.out_alloc_fail !== m_fail ||
          bus.out_rel_err !== m_err || bus.out_drop_cnt !== 16'(m_drop)) begin
        n_fail++;
        $display("FAIL rnd_state[%0d]: cnt=%0d ae=%b af=%b re=%b drop=%0d required %0d %b %b %b %0d",
                 n, bus.out_free_cnt, bus.out_almost_empty, bus.out_alloc_fail, bus.out_rel_err,
                 bus.out_drop_cnt, q.size(), m_ae, m_fail, m_err, m_drop);
      end
    end
  endtask
  task automatic test_midreset();
    do_reset();
    repeat (NUM) cycle(0, 0, 0);
    repeat (10) cycle(1, 0, 0);
    n_chk++;
    if (bus.out_free_cnt !== 5'd6) begin
      n_fail++;
      $display("FAIL pre_reset_cnt: got %0d required 6", bus.out_free_cnt);
    end
    rst = 1'b1;
    #1;
    model_reset();
    n_chk++;
    if ({bus.out_id, bus.out_id_vld, bus.out_free_cnt, bus.out_almost_empty, bus.out_alloc_fail,
         bus.out_rel_err, bus.out_drop_cnt, bus.out_init_done} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: id=%0h vld=%b cnt=%0d ae=%b af=%b re=%b drop=%0d done=%b, required all 0",
               bus.out_id, bus.out_id_vld, bus.out_free_cnt, bus.out_almost_empty, bus.out_alloc_fail,
               bus.out_rel_err, bus.out_drop_cnt, bus.out_init_done);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (NUM) cycle(0, 0, 0);
    n_chk++;
    if (bus.out_init_done !== 1'b1 || bus.out_free_cnt !== 5'd16 || bus.out_drop_cnt !== 16'd0 || bus.out_id !== 8'd0) begin
      n_fail++;
      $display("FAIL reinit: done=%b cnt=%0d drop=%0d id=%0d required 1 16 0 0",
               bus.out_init_done, bus.out_free_cnt, bus.out_drop_cnt, bus.out_id);
    end
    cycle(0, 1, 8'd4);
    n_chk++;
    if (bus.out_rel_err !== 1'b1 || bus.out_free_cnt !== 5'd16) begin
      n_fail++;
      $display("FAIL full_release: err=%b cnt=%0d required 1 16", bus.out_rel_err, bus.out_free_cnt);
    end
  endtask
  task automatic test_init_requests();
    do_reset();
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    n_chk++;
    if (bus.out_alloc_fail !== 1'b1 || bus.out_drop_cnt !== 16'd1 || bus.out_free_cnt !== 5'd2) begin
      n_fail++;
      $display("FAIL init_alloc: fail=%b drop=%0d cnt=%0d required 1 1 2",
               bus.out_alloc_fail, bus.out_drop_cnt, bus.out_free_cnt);
    end
    cycle(0, 1, 8'd0);
    n_chk++;
    if (bus.out_rel_err !== 1'b1 || bus.out_free_cnt !== 5'd3) begin
      n_fail++;
      $display("FAIL init_release: err=%b cnt=%0d required 1 3", bus.out_rel_err, bus.out_free_cnt);
    end
    repeat (NUM - 3) cycle(0, 0, 0);
    n_chk++;
    if (bus.out_init_done !== 1'b1 || bus.out_free_cnt !== 5'd16) begin
      n_fail++;
      $display("FAIL init_latency_kept: done=%b cnt=%0d required 1 16", bus.out_init_done, bus.out_free_cnt);
    end
  endtask
  initial begin
    bus.in_alloc_req = 1'b0;
    bus.in_rel_wr = 1'b0;
    bus.in_rel_id = '0;
    test_reset();
    test_drain();
    test_release_order();
    test_errors();
    test_simultaneous();
    test_random();
    test_midreset();
    test_init_requests();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
